// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core/debug memory arbiter.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selector for the memory arbiter: fixed core-first priority with a debug
// starvation guard, or round-robin when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic core_elig,
  input  logic dbg_elig,
  output logic pick_core,
  output logic pick_dbg
);

`ifdef ARB_ROUND_ROBIN_EN

  logic last_winner_q, last_winner_d;

  always_comb begin
    pick_core = 1'b0;
    pick_dbg  = 1'b0;
    if (arb_en) begin
      if (core_elig && dbg_elig) begin
        if (last_winner_q == REQ_CORE) pick_dbg = 1'b1;
        else                           pick_core = 1'b1;
      end else if (core_elig) begin
        pick_core = 1'b1;
      end else if (dbg_elig) begin
        pick_dbg = 1'b1;
      end
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (pick_core)     last_winner_d = REQ_CORE;
    else if (pick_dbg) last_winner_d = REQ_DBG;
  end

  always_ff @(posedge clk) begin
    if (reset) last_winner_q <= REQ_DBG;
    else       last_winner_q <= last_winner_d;
  end

`else

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    pick_core = 1'b0;
    pick_dbg  = 1'b0;
    if (arb_en) begin
      if (core_elig && dbg_elig) begin
        if (starve_cnt_q == LIMIT) pick_dbg = 1'b1;
        else                       pick_core = 1'b1;
      end else if (core_elig) begin
        pick_core = 1'b1;
      end else if (dbg_elig) begin
        pick_dbg = 1'b1;
      end
    end
  end

  // Counter only moves in arbitration cycles, so it holds across RD_WAIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_en) begin
      if (!dbg_elig || pick_dbg)   starve_cnt_d = '0;
      else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified single-port memory between the core and the debug/loader
// port, tracks the one-cycle read latency and stalls the core. Macro: ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_adr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic          core_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_adr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  input  logic          dbg_lock,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          core_elig, dbg_elig, arb_en;
  logic          pick_core, pick_dbg;

  // if-based qualification turns an unknown request into "not requesting",
  // so it cannot reach the grant or mem_we paths.
  always_comb begin
    core_elig = 1'b0;
    dbg_elig  = 1'b0;
    if (core_req && !dbg_lock) core_elig = 1'b1;
    if (dbg_req)               dbg_elig  = 1'b1;
    arb_en = (state_q == IDLE) && !reset;
  end

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_pick (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (arb_en),
    .core_elig(core_elig),
    .dbg_elig (dbg_elig),
    .pick_core(pick_core),
    .pick_dbg (pick_dbg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ_CORE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_core && !core_we) begin
          state_d = RD_WAIT;
          owner_d = REQ_CORE;
        end else if (pick_dbg && !dbg_we) begin
          state_d = RD_WAIT;
          owner_d = REQ_DBG;
        end
      end
      RD_WAIT: begin
        state_d = IDLE;
        rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is high, which also drops an in-flight read.
  always_comb begin
    core_gnt    = 1'b0;
    dbg_gnt     = 1'b0;
    core_rvalid = 1'b0;
    dbg_rvalid  = 1'b0;
    core_stall  = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_adr     = '0;
    mem_wdata   = '0;
    rdata       = rdata_q;
    if (!reset) begin
      core_gnt = pick_core;
      dbg_gnt  = pick_dbg;
      if (pick_core) begin
        mem_en    = 1'b1;
        mem_we    = core_we;
        mem_adr   = core_adr;
        mem_wdata = core_wdata;
      end else if (pick_dbg) begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_adr   = dbg_adr;
        mem_wdata = dbg_wdata;
      end
      if (state_q == RD_WAIT) begin
        rdata       = mem_rdata;
        core_rvalid = (owner_q == REQ_CORE);
        dbg_rvalid  = (owner_q == REQ_DBG);
        if (owner_q == REQ_CORE) core_stall = 1'b1;
      end
      if (core_req && !pick_core) core_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a memory stub plus a read-data scoreboard.
// Round-robin expectations are used when ARB_ROUND_ROBIN_EN is defined.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] core_adr, dbg_adr, mem_adr;
  logic [DW-1:0] core_wdata, dbg_wdata, mem_wdata, rdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          core_gnt, core_rvalid, core_stall, dbg_gnt, dbg_rvalid;
  logic          mem_en, mem_we;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] mem [0:255];

  mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_lock(dbg_lock),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem[mem_adr[9:2]] <= mem_wdata;
      else                 mem_rdata <= mem[mem_adr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_adr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_adr  = '0; dbg_wdata  = '0;
    dbg_lock = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    core_req = 1'b1; core_we = 1'b1; core_adr = 32'h20;
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_stall, mem_en, mem_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_hold_strobes: got %b expected 0000000",
               {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_stall, mem_en, mem_we});
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_stall, mem_en, mem_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_stall, mem_en, mem_we});
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h expected 00000000", rdata);
    end
    checks++;
    if ({mem_adr, mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_mem_bus: got adr %h wdata %h expected 0/0", mem_adr, mem_wdata);
    end
  endtask

  task automatic test_back_to_back_writes();
    logic [DW-1:0] prog [4] = '{32'hE3A00005, 32'hE3A01007, 32'hE0802001, 32'hE5802040};
    for (int i = 0; i < 4; i++) begin
      tick();
      dbg_req = 1'b1; dbg_we = 1'b1;
      dbg_adr = 32'h10 + 32'(4 * i); dbg_wdata = prog[i];
      @(negedge clk);
      checks++;
      if ({dbg_gnt, core_gnt, mem_en, mem_we} !== 4'b1011 || mem_adr !== dbg_adr || mem_wdata !== prog[i]) begin
        failures++;
        $display("FAIL b2b_write_%0d: got gnt=%b cgnt=%b en=%b we=%b adr=%h wd=%h expected 1 0 1 1 %h %h",
                 i, dbg_gnt, core_gnt, mem_en, mem_we, mem_adr, mem_wdata, dbg_adr, prog[i]);
      end
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, mem_en, mem_we, core_stall} !== 5'b0) begin
      failures++;
      $display("FAIL no_request_idle: got %b expected 00000",
               {core_gnt, dbg_gnt, mem_en, mem_we, core_stall});
    end
  endtask

  task automatic test_core_read();
    exp_t e;
    tick();
    core_req = 1'b1; core_we = 1'b0; core_adr = 32'h10;
    @(negedge clk);
    checks++;
    if ({core_gnt, mem_en, mem_we, core_stall} !== 4'b1100 || mem_adr !== 32'h10) begin
      failures++;
      $display("FAIL core_read_grant: got gnt=%b en=%b we=%b stall=%b adr=%h expected 1 1 0 0 00000010",
               core_gnt, mem_en, mem_we, core_stall, mem_adr);
    end
    if (core_gnt === 1'b1) exp_q.push_back('{port: REQ_CORE, data: 32'hE3A00005});
    tick();
    core_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_stall, core_gnt, mem_en} !== 3'b100) begin
      failures++;
      $display("FAIL core_read_wait: got stall=%b gnt=%b en=%b expected 1 0 0", core_stall, core_gnt, mem_en);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL core_read_data: got rvalid=%b with no pending read expected a pending read", core_rvalid);
    end else begin
      e = exp_q.pop_front();
      if ({core_rvalid, dbg_rvalid, rdata} !== {e.port == REQ_CORE, e.port == REQ_DBG, e.data}) begin
        failures++;
        $display("FAIL core_read_data: got rv=%b/%b rdata=%h expected %b/%b %h", core_rvalid, dbg_rvalid,
                 rdata, e.port == REQ_CORE, e.port == REQ_DBG, e.data);
      end
    end
    tick();
    core_req = 1'b1; core_adr = 32'h14;
    @(negedge clk);
    checks++;
    if ({core_gnt, core_rvalid, core_stall} !== 3'b100 || rdata !== 32'hE3A00005) begin
      failures++;
      $display("FAIL core_read_back_idle: got gnt=%b rv=%b stall=%b rdata=%h expected 1 0 0 e3a00005",
               core_gnt, core_rvalid, core_stall, rdata);
    end
    if (core_gnt === 1'b1) exp_q.push_back('{port: REQ_CORE, data: 32'hE3A01007});
    tick();
    core_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL core_read2_data: got rvalid=%b with no pending read expected a pending read", core_rvalid);
    end else begin
      e = exp_q.pop_front();
      if ({core_rvalid, dbg_rvalid, rdata} !== {e.port == REQ_CORE, e.port == REQ_DBG, e.data}) begin
        failures++;
        $display("FAIL core_read2_data: got rv=%b/%b rdata=%h expected %h", core_rvalid, dbg_rvalid, rdata, e.data);
      end
    end
  endtask

  task automatic test_dbg_lock_write();
    exp_t e;
    tick();
    dbg_lock = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_adr = 32'h40;
    dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_adr  = 32'h40; dbg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({dbg_gnt, core_gnt, mem_we, core_stall} !== 4'b1011 || mem_adr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lock_dbg_write: got dgnt=%b cgnt=%b we=%b stall=%b adr=%h wd=%h expected 1 0 1 1 00000040 deadbeef",
               dbg_gnt, core_gnt, mem_we, core_stall, mem_adr, mem_wdata);
    end
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({core_gnt, core_stall, mem_en} !== 3'b010) begin
        failures++;
        $display("FAIL lock_core_blocked_%0d: got gnt=%b stall=%b en=%b expected 0 1 0", i, core_gnt, core_stall, mem_en);
      end
      tick();
    end
    dbg_lock = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_gnt, mem_we} !== 2'b10 || mem_adr !== 32'h40) begin
      failures++;
      $display("FAIL lock_release_grant: got gnt=%b we=%b adr=%h expected 1 0 00000040", core_gnt, mem_we, mem_adr);
    end
    if (core_gnt === 1'b1) exp_q.push_back('{port: REQ_CORE, data: 32'hDEADBEEF});
    tick();
    core_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL lock_readback: got rvalid=%b with no pending read expected a pending read", core_rvalid);
    end else begin
      e = exp_q.pop_front();
      if ({core_rvalid, dbg_rvalid, rdata} !== {e.port == REQ_CORE, e.port == REQ_DBG, e.data}) begin
        failures++;
        $display("FAIL lock_readback: got rv=%b/%b rdata=%h expected %h", core_rvalid, dbg_rvalid, rdata, e.data);
      end
    end
  endtask

  task automatic test_lock_in_rd_wait();
    exp_t e;
    tick();
    core_req = 1'b1; core_we = 1'b0; core_adr = 32'h40;
    @(negedge clk);
    checks++;
    if (core_gnt !== 1'b1) begin
      failures++;
      $display("FAIL lock_rdw_grant: got %b expected 1", core_gnt);
    end
    if (core_gnt === 1'b1) exp_q.push_back('{port: REQ_CORE, data: 32'hDEADBEEF});
    tick();
    dbg_lock = 1'b1; core_adr = 32'h10;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL lock_rdw_complete: got rvalid=%b with no pending read expected a pending read", core_rvalid);
    end else begin
      e = exp_q.pop_front();
      if ({core_rvalid, dbg_rvalid, core_stall, rdata} !== {e.port == REQ_CORE, e.port == REQ_DBG, 1'b1, e.data}) begin
        failures++;
        $display("FAIL lock_rdw_complete: got rv=%b/%b stall=%b rdata=%h expected 1/0 1 %h",
                 core_rvalid, dbg_rvalid, core_stall, rdata, e.data);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if ({core_gnt, core_stall} !== 2'b01) begin
      failures++;
      $display("FAIL lock_rdw_next_idle: got gnt=%b stall=%b expected 0 1", core_gnt, core_stall);
    end
    tick();
    idle_inputs();
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic exp_core;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_adr = 32'h80; core_wdata = 32'h11111111;
    dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_adr  = 32'h84; dbg_wdata  = 32'h22222222;
    exp_core = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({core_gnt, dbg_gnt, mem_we} !== {exp_core, ~exp_core, 1'b1}) begin
        failures++;
        $display("FAIL rr_grant_%0d: got cgnt=%b dgnt=%b we=%b expected %b %b 1",
                 i, core_gnt, dbg_gnt, mem_we, exp_core, ~exp_core);
      end
      exp_core = ~exp_core;
      tick();
    end
    idle_inputs();
  endtask
`else
  task automatic test_starvation();
    exp_t e;
    int   attempts = 0;
    int   dbg_wins = 0;
    int   exp_att;
    tick();
    core_req = 1'b1; core_we = 1'b0; core_adr = 32'h10;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_adr  = 32'h40;
    for (int c = 0; c < 80 && dbg_wins < 2; c++) begin
      @(negedge clk);
      if (core_rvalid === 1'b1 || dbg_rvalid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL starve_read: got rvalid %b/%b with no pending read expected a pending read",
                   core_rvalid, dbg_rvalid);
        end else begin
          e = exp_q.pop_front();
          if ({core_rvalid, dbg_rvalid, rdata} !== {e.port == REQ_CORE, e.port == REQ_DBG, e.data}) begin
            failures++;
            $display("FAIL starve_read: got rv=%b/%b rdata=%h expected %b/%b %h", core_rvalid, dbg_rvalid,
                     rdata, e.port == REQ_CORE, e.port == REQ_DBG, e.data);
          end
        end
      end
      if (core_gnt === 1'b1 || dbg_gnt === 1'b1) begin
        attempts++;
        if (dbg_gnt === 1'b1) begin
          exp_q.push_back('{port: REQ_DBG, data: 32'hDEADBEEF});
          dbg_wins++;
          exp_att = (dbg_wins == 1) ? int'(LIMIT) + 1 : 2 * (int'(LIMIT) + 1);
          checks++;
          if (attempts != exp_att) begin
            failures++;
            $display("FAIL starve_dbg_win_%0d: got attempt %0d expected attempt %0d", dbg_wins, attempts, exp_att);
          end
        end else begin
          exp_q.push_back('{port: REQ_CORE, data: 32'hE3A00005});
        end
      end
      tick();
    end
    checks++;
    if (dbg_wins != 2) begin
      failures++;
      $display("FAIL starve_timeout: got %0d debug wins expected 2", dbg_wins);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL starve_last_read: got rvalid %b/%b with no pending read expected a pending read",
               core_rvalid, dbg_rvalid);
    end else begin
      e = exp_q.pop_front();
      if ({core_rvalid, dbg_rvalid, rdata} !== {e.port == REQ_CORE, e.port == REQ_DBG, e.data}) begin
        failures++;
        $display("FAIL starve_last_read: got rv=%b/%b rdata=%h expected %h", core_rvalid, dbg_rvalid, rdata, e.data);
      end
    end
  endtask
`endif

  task automatic test_reset_in_rd_wait();
    exp_t e;
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h40;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rst_rdw_grant: got %b expected 1", dbg_gnt);
    end
    tick();
    dbg_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, core_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_rdw_no_rvalid: got %b expected 00", {dbg_rvalid, core_rvalid});
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_stall, mem_en, mem_we} !== 7'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_rdw_after: got strobes %b rdata %h expected 0000000 00000000",
               {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_stall, mem_en, mem_we}, rdata);
    end
    tick();
    dbg_req = 1'b1; dbg_adr = 32'h10;
    @(negedge clk);
    checks++;
    if ({dbg_gnt, mem_en, mem_we} !== 3'b110 || mem_adr !== 32'h10) begin
      failures++;
      $display("FAIL rst_rdw_regrant: got gnt=%b en=%b we=%b adr=%h expected 1 1 0 00000010",
               dbg_gnt, mem_en, mem_we, mem_adr);
    end
    if (dbg_gnt === 1'b1) exp_q.push_back('{port: REQ_DBG, data: 32'hE3A00005});
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL rst_rdw_read: got rvalid=%b with no pending read expected a pending read", dbg_rvalid);
    end else begin
      e = exp_q.pop_front();
      if ({core_rvalid, dbg_rvalid, rdata} !== {e.port == REQ_CORE, e.port == REQ_DBG, e.data}) begin
        failures++;
        $display("FAIL rst_rdw_read: got rv=%b/%b rdata=%h expected 0/1 %h", core_rvalid, dbg_rvalid, rdata, e.data);
      end
    end
  endtask

  task automatic test_x_request();
    logic exp_we;
    tick();
    core_req = 1'bx; core_we = 1'b1; core_adr = 32'hC0; dbg_req = 1'b0;
    exp_we = (core_req === 1'b1);
    @(negedge clk);
    checks++;
    if (mem_we !== exp_we) begin
      failures++;
      $display("FAIL x_core_req_we: got %b expected %b", mem_we, exp_we);
    end
    tick();
    core_req = 1'b0; core_we = 1'b0;
    dbg_req = 1'bx; dbg_we = 1'b1; dbg_adr = 32'hC4;
    exp_we = (dbg_req === 1'b1);
    @(negedge clk);
    checks++;
    if (mem_we !== exp_we) begin
      failures++;
      $display("FAIL x_dbg_req_we: got %b expected %b", mem_we, exp_we);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back_writes();
    test_core_read();
    test_dbg_lock_write();
    test_lock_in_rd_wait();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_reset_in_rd_wait();
    test_x_request();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle ARM core between two requesters.
- Requester 0 is the core: instruction fetch and LDR/STR traffic, driven by the core's Adr/MemWrite/WriteData.
- Requester 1 is the debug/loader port, used for program load and memory inspection.
- Sequences each access through a small FSM, handles the memory's one-cycle synchronous read latency, and produces a stall to the core controller while the core waits.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_LIMIT, 8, consecutive lost arbitration cycles after which the debug port is forced to win; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request; held with address/data stable until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_adr  in  AW  core byte address.
- core_wdata  in  DW  core write data.
- core_gnt  out  1  request accepted this cycle.
- core_rvalid  out  1  read data for the core is valid this cycle.
- core_stall  out  1  core_req & ~core_gnt, or core read outstanding; freezes the core controller FSM.
- dbg_req, dbg_we, dbg_adr, dbg_wdata, dbg_gnt, dbg_rvalid  same directions/widths/meanings for the debug port.
- dbg_lock  in  1  while high, the core is never granted.
- rdata  out  DW  read data, shared; qualified by the *_rvalid outputs.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe.

Behaviour:
- Reset: state=IDLE, owner=0, starve_cnt=0, last_winner=1.
- Reset values of all outputs: gnt, rvalid, stall, mem_en and mem_we are 0. rdata, mem_adr and mem_wdata are 0.
- States: IDLE, RD_WAIT.
- IDLE, arbitration:
  - Eligible requesters are core (core_req & ~dbg_lock) and dbg (dbg_req).
  - If both are eligible, the core wins, unless starve_cnt == STARVE_LIMIT, in which case dbg wins.
  - The winner gets gnt=1 combinationally in the same cycle, with mem_en=1, mem_adr and mem_wdata muxed from the winner, and mem_we = winner_we.
- IDLE, write grant: the transaction completes in that cycle; state stays IDLE. Back-to-back writes give 1 access per cycle.
- IDLE, read grant: owner <= winner; state goes to RD_WAIT.
- RD_WAIT:
  - rdata = mem_rdata; owner's rvalid=1.
  - No grant is issued and mem_en=0.
  - Next state is IDLE. Read throughput is 1 per 2 cycles.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) in each IDLE cycle where dbg_req=1 and dbg loses.
  - Clears to 0 when dbg is granted or dbg_req=0.
  - Holds its value in RD_WAIT.
- core_stall: high while core_req=1 and no core_gnt, and also during RD_WAIT when owner=core. A core read therefore stalls exactly 1 cycle after grant when uncontended.
- No requests in IDLE: all strobes are 0; rdata holds its last value.
- dbg_lock asserted mid-RD_WAIT with owner=core: the in-flight read still completes (core_rvalid=1); the lock applies from the next IDLE cycle.
- Request dropped before grant: legal; no side effect.
- Request dropped after grant: the transaction is already committed.
- Reset during RD_WAIT: the read is abandoned, no rvalid is produced, and state returns to IDLE next cycle.
- Any X on *_req must not propagate to mem_we; the bench checks this.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Replaces core-first priority with round-robin. On a tie, the requester ≠ last_winner wins.
  - last_winner updates on every grant.
  - starve_cnt logic is removed; STARVE_LIMIT is ignored.
  - dbg_lock still masks the core.
- ARB_ROUND_ROBIN_EN undefined: fixed priority with starvation guard, as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, RD_WAIT
  - requester ID constants: REQ_CORE=0, REQ_DBG=1
  - default AW/DW constants
- One natural sub-module: arb_pick, a combinational/registered winner selector holding last_winner and starve_cnt.
- The FSM, muxing and rvalid generation stay in mem_arbiter.

Test Plan:
- Core read, address 0x10, mem holds 0xE3A00005 → core_gnt at cycle 0, core_stall=1 at cycle 1, core_rvalid=1 with rdata=0xE3A00005 at cycle 1, IDLE at cycle 2.
- dbg writes 0xDEADBEEF to 0x40 with dbg_lock=1 while core_req=1, followed by a core read of 0x40 after lock release → core never granted during lock; core then reads 0xDEADBEEF.
- Core and dbg both continuously requesting reads, fixed priority, STARVE_LIMIT=8 → dbg granted at its 9th arbitration attempt; starve_cnt returns to 0 afterwards.
- With ARB_ROUND_ROBIN_EN, both requesting writes every cycle → grants alternate core, dbg, core, dbg, …; mem_we=1 every cycle.
- Reset asserted during RD_WAIT of a dbg read → dbg_rvalid never asserted; all outputs 0 in the cycle after reset; the next request is granted normally.
